pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with not-taken speculation, branch resolve and flush squash
module pc_sequencer #(
  parameter int                     PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC     = '0,
  parameter int                     FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                is_branch,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                branchIdea,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                fetch_valid,
  output logic                flush,
  output logic                resolving,
  output logic [7:0]          taken_count
);

  typedef enum logic [1:0] {RUN, RESOLVE, FLUSH, HALTED} state_t;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] target_q, target_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [7:0]          tc_q, tc_d;
  logic                flush_q, flush_d;
  logic                fv_q, fv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      target_q <= '0;
      cnt_q    <= '0;
      tc_q     <= '0;
      flush_q  <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      flush_q  <= flush_d;
      fv_q     <= fv_d;
    end
  end

  // A stall freezes every register, including a pending flush pulse, so it is
  // presented on the first unstalled cycle instead of being lost.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    tc_d     = tc_q;
    flush_d  = flush_q;
    fv_d     = fv_q;
    if (!stall) begin
      flush_d = 1'b0;
      case (state_q)
        RUN: begin
          if (halt) begin
            state_d = HALTED;
            fv_d    = 1'b0;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
            fv_d = 1'b1;
            if (is_branch) begin
              target_d = pc_q + branch_offset;
              state_d  = RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (branchIdea) begin
            pc_d    = target_q;
            flush_d = 1'b1;
            fv_d    = 1'b0;
            tc_d    = (tc_q != 8'hFF) ? tc_q + 8'd1 : tc_q;
            cnt_d   = FLUSH_LAST;
            state_d = FLUSH;
          end else begin
            pc_d    = pc_q + PC_WIDTH'(1);
            fv_d    = 1'b1;
            state_d = RUN;
          end
        end
        FLUSH: begin
          fv_d = 1'b0;
          if (halt) begin
            state_d = HALTED;
          end else if (cnt_q == 3'd0) begin
            // Target becomes the live fetch on the first RUN cycle.
            fv_d    = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        HALTED: fv_d = 1'b0;
        default: state_d = RUN;
      endcase
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fv_q & ~stall;
  assign flush       = flush_q & ~stall;
  assign resolving   = (state_q == RESOLVE);
  assign taken_count = tc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  typedef struct packed {
    logic [31:0] tag;
    logic [15:0] pc;
    logic        fv;
    logic        fl;
    logic        rs;
    logic [7:0]  tc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        is_branch = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        branchIdea = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        resolving;
  logic [7:0]  taken_count;

  logic [31:0] cycle = '0;
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tc_m;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch),
    .branch_offset(branch_offset), .branchIdea(branchIdea), .halt(halt),
    .pc(pc), .fetch_valid(fetch_valid), .flush(flush),
    .resolving(resolving), .taken_count(taken_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v, input logic [31:0] tag);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, tag, act, exp_v);
    end
  endtask

  // Monitor: compares the outputs presented in each cycle against the queued expectation.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].tag <= cycle) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.tag != cycle) begin
        checks++;
        errors++;
        $display("FAIL missed_sample: tag %0d seen at cycle %0d", e.tag, cycle);
      end else begin
        chk("pc", {16'd0, pc}, {16'd0, e.pc}, e.tag);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv}, e.tag);
        chk("flush", {31'd0, flush}, {31'd0, e.fl}, e.tag);
        chk("resolving", {31'd0, resolving}, {31'd0, e.rs}, e.tag);
        chk("taken_count", {24'd0, taken_count}, {24'd0, e.tc}, e.tag);
      end
    end
  end

  // Drives this cycle's inputs and queues the outputs expected in this same cycle.
  task automatic st(input logic s, input logic b, input logic bi, input logic h,
                    input logic [15:0] off, input logic [15:0] e_pc,
                    input logic e_fv, input logic e_fl, input logic e_rs, input logic [7:0] e_tc);
    exp_t e;
    stall = s; is_branch = b; branchIdea = bi; halt = h; branch_offset = off;
    e.tag = cycle; e.pc = e_pc; e.fv = e_fv; e.fl = e_fl; e.rs = e_rs; e.tc = e_tc;
    sb_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    st(0,0,0,0,16'h0, 16'h0000,0,0,0,8'd0);
    rst_n = 1'b1;
    st(0,0,0,0,16'h0, 16'h0000,0,0,0,8'd0);
    // Sequential run, then taken branch at 0x0010 with +8.
    for (int i = 1; i <= 16; i++)
      st(0, (i == 16), 0, 0, 16'h0008, 16'(i), 1, 0, 0, 8'd0);
    st(0,0,1,0,16'h0, 16'h0011,1,0,1,8'd0);
    st(0,0,0,0,16'h0, 16'h0018,0,1,0,8'd1);
    st(0,0,0,0,16'h0, 16'h0018,0,0,0,8'd1);
    st(0,0,0,0,16'h0, 16'h0018,1,0,0,8'd1);
    // Reset while resolving a taken branch abandons it.
    st(0,1,0,0,16'h0004, 16'h0019,1,0,0,8'd1);
    rst_n = 1'b0;
    st(0,0,1,0,16'h0, 16'h0000,0,0,0,8'd0);
    st(0,0,1,0,16'h0, 16'h0000,0,0,0,8'd0);
    rst_n = 1'b1;
    st(0,0,0,0,16'h0, 16'h0000,0,0,0,8'd0);
    // Not-taken backward branch at 0x0010.
    for (int i = 1; i <= 16; i++)
      st(0, (i == 16), 0, 0, 16'hFFF0, 16'(i), 1, 0, 0, 8'd0);
    st(0,0,0,0,16'h0, 16'h0011,1,0,1,8'd0);
    // Taken branch to 0xFFFF, then wrapping branch to 0x0002 with stalled resolve.
    st(0,1,0,0,16'hFFED, 16'h0012,1,0,0,8'd0);
    st(0,0,1,0,16'h0, 16'h0013,1,0,1,8'd0);
    st(0,0,0,0,16'h0, 16'hFFFF,0,1,0,8'd1);
    st(0,0,0,0,16'h0, 16'hFFFF,0,0,0,8'd1);
    st(0,1,0,0,16'h0003, 16'hFFFF,1,0,0,8'd1);
    for (int i = 0; i < 3; i++)
      st(1,0,1,0,16'h0, 16'h0000,0,0,1,8'd1);
    st(0,0,1,0,16'h0, 16'h0000,1,0,1,8'd1);
    st(0,0,0,0,16'h0, 16'h0002,0,1,0,8'd2);
    st(0,0,0,0,16'h0, 16'h0002,0,0,0,8'd2);
    // 300 zero-offset taken branches: count saturates at 255.
    tc_m = 8'd2;
    for (int i = 0; i < 300; i++) begin
      st(0,1,0,0,16'h0, 16'h0002,1,0,0,tc_m);
      st(0,0,1,0,16'h0, 16'h0003,1,0,1,tc_m);
      if (tc_m != 8'd255) tc_m = tc_m + 8'd1;
      st(0,0,0,0,16'h0, 16'h0002,0,1,0,tc_m);
      st(0,0,0,0,16'h0, 16'h0002,0,0,0,tc_m);
    end
    // Halt ignored in RESOLVE, honoured in RUN over is_branch, then held.
    st(0,1,0,0,16'h0010, 16'h0002,1,0,0,8'd255);
    st(0,1,0,1,16'h0010, 16'h0003,1,0,1,8'd255);
    st(0,1,0,1,16'h0010, 16'h0004,1,0,0,8'd255);
    for (int i = 0; i < 3; i++)
      st(0,1,1,0,16'h0010, 16'h0004,0,0,0,8'd255);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
